id_ex_pipe_reg: RTL and testbench

Parametrised ID/EX pipeline register for the five-stage MIPS datapath, sitting between the decode stage (register file read, control unit) and the execute stage (ALU, forwarding muxes). Over the plain stage register it adds a valid bit, stall (hold) and flush (bubble) control, and sign/zero immediate extension to the datapath width. It also adds load-use hazard detection against the instruction currently in decode and a saturating counter of inserted bubbles.

---
 rtl/id_ex_pipe_reg.sv | 82 ++++++++
 tb/tb_id_ex_pipe_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: valid/stall/flush control, immediate extension,
// load-use hazard detection and a saturating count of inserted bubbles.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [25:0]       id_instr,
  input  logic              id_imm_sext,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs_addr,
  output logic [4:0]        ex_rt_addr,
  output logic [4:0]        ex_rd_addr,
  output logic              load_use_hazard,
  output logic [CNT_W-1:0]  bubble_count
);

  logic [DATA_W-1:0] imm_ext;

  always_comb begin
    imm_ext = {{(DATA_W-16){id_imm_sext & id_instr[15]}}, id_instr[15:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs_addr <= '0;
      ex_rt_addr <= '0;
      ex_rd_addr <= '0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs_addr <= '0;
      ex_rt_addr <= '0;
      ex_rd_addr <= '0;
    end else if (!stall) begin
      ex_valid   <= id_valid;
      // An invalid slot must never carry write enables into EX.
      ex_ctrl    <= id_valid ? id_ctrl : '0;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= imm_ext;
      ex_rs_addr <= id_instr[25:21];
      ex_rt_addr <= id_instr[20:16];
      ex_rd_addr <= id_instr[15:11];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (flush && (bubble_count != '1)) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

  always_comb begin
    load_use_hazard = ex_valid && ex_ctrl[2] && (ex_rt_addr != 5'd0) &&
                      ((ex_rt_addr == id_instr[25:21]) ||
                       (ex_rt_addr == id_instr[20:16]));
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a default instance plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid, id_imm_sext;
  logic [6:0]  id_ctrl;
  logic [31:0] id_rs_data, id_rt_data;
  logic [25:0] id_instr;

  logic        ex_valid, load_use_hazard;
  logic [6:0]  ex_ctrl;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;
  logic [15:0] bubble_count;

  logic        ex_valid_b, load_use_hazard_b;
  logic [6:0]  ex_ctrl_b;
  logic [31:0] ex_rs_data_b, ex_rt_data_b, ex_imm_b;
  logic [4:0]  ex_rs_addr_b, ex_rt_addr_b, ex_rd_addr_b;
  logic [1:0]  bubble_count_b;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(32), .CTRL_W(7), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_instr(id_instr), .id_imm_sext(id_imm_sext),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr),
    .load_use_hazard(load_use_hazard), .bubble_count(bubble_count)
  );

  id_ex_pipe_reg #(.DATA_W(32), .CTRL_W(7), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_instr(id_instr), .id_imm_sext(id_imm_sext),
    .ex_valid(ex_valid_b), .ex_ctrl(ex_ctrl_b),
    .ex_rs_data(ex_rs_data_b), .ex_rt_data(ex_rt_data_b), .ex_imm(ex_imm_b),
    .ex_rs_addr(ex_rs_addr_b), .ex_rt_addr(ex_rt_addr_b), .ex_rd_addr(ex_rd_addr_b),
    .load_use_hazard(load_use_hazard_b), .bubble_count(bubble_count_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " valid"},  64'(ex_valid), 64'd0);
    check({tag, " ctrl"},   64'(ex_ctrl), 64'd0);
    check({tag, " rs_data"}, 64'(ex_rs_data), 64'd0);
    check({tag, " rt_data"}, 64'(ex_rt_data), 64'd0);
    check({tag, " imm"},    64'(ex_imm), 64'd0);
    check({tag, " addrs"},  64'({ex_rs_addr, ex_rt_addr, ex_rd_addr}), 64'd0);
    check({tag, " hazard"}, 64'(load_use_hazard), 64'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_imm_sext = 1'b0;
    id_ctrl = '0; id_rs_data = '0; id_rt_data = '0; id_instr = '0;
    tick();
    tick();
    rst = 1'b0;
    check_cleared("reset");
    check("reset bubble", 64'(bubble_count), 64'd0);

    // Normal load, sign-extended immediate: rs=5, rt=1, rd=16, imm=0x8004
    id_valid = 1'b1; id_ctrl = 7'h54; id_instr = 26'h0A1_8004; id_imm_sext = 1'b1;
    id_rs_data = 32'h1234_5678; id_rt_data = 32'h9ABC_DEF0;
    tick();
    check("load valid",   64'(ex_valid), 64'd1);
    check("load ctrl",    64'(ex_ctrl), 64'h54);
    check("load rs_addr", 64'(ex_rs_addr), 64'd5);
    check("load rt_addr", 64'(ex_rt_addr), 64'd1);
    check("load rd_addr", 64'(ex_rd_addr), 64'd16);
    check("load imm sext", 64'(ex_imm), 64'hFFFF_8004);
    check("load rs_data", 64'(ex_rs_data), 64'h1234_5678);
    check("load rt_data", 64'(ex_rt_data), 64'h9ABC_DEF0);
    // ctrl 0x54 has Mem_r set and id rt (1) matches ex rt (1)
    check("load hazard self", 64'(load_use_hazard), 64'd1);
    id_imm_sext = 1'b0;
    tick();
    check("load imm zext", 64'(ex_imm), 64'h0000_8004);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check_cleared("async rst");
    rst = 1'b0;

    // Stall then stall+flush; instr 0x1234567: rs=9, rt=3, rd=8, imm=0x4567
    id_valid = 1'b1; id_ctrl = 7'h12; id_instr = 26'h123_4567; id_imm_sext = 1'b1;
    id_rs_data = 32'h0000_AAAA; id_rt_data = 32'h0000_5555;
    tick();
    check("pre-stall ctrl", 64'(ex_ctrl), 64'h12);
    check("pre-stall addrs", 64'({ex_rs_addr, ex_rt_addr, ex_rd_addr}),
          64'({5'd9, 5'd3, 5'd8}));
    check("pre-stall imm", 64'(ex_imm), 64'h0000_4567);
    stall = 1'b1; id_valid = 1'b0; id_ctrl = 7'h7F; id_instr = 26'h3FF_FFFF;
    id_rs_data = 32'hDEAD_BEEF; id_rt_data = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall valid",   64'(ex_valid), 64'd1);
      check("stall ctrl",    64'(ex_ctrl), 64'h12);
      check("stall rs_data", 64'(ex_rs_data), 64'h0000_AAAA);
      check("stall rt_data", 64'(ex_rt_data), 64'h0000_5555);
      check("stall imm",     64'(ex_imm), 64'h0000_4567);
      check("stall addrs",   64'({ex_rs_addr, ex_rt_addr, ex_rd_addr}),
            64'({5'd9, 5'd3, 5'd8}));
    end
    flush = 1'b1;
    tick();
    check_cleared("flush");
    check("flush bubble", 64'(bubble_count), 64'd1);
    flush = 1'b0; stall = 1'b0;

    // Load-use: EX load with rt=8 (instr rs=2, rt=8)
    id_valid = 1'b1; id_ctrl = 7'h34; id_instr = 26'h048_0010;
    tick();
    check("lu rt_addr", 64'(ex_rt_addr), 64'd8);
    check("lu match rt", 64'(load_use_hazard), 64'd1);
    id_instr = 26'h068_0000;   // rs=3, rt=8
    #1 check("lu match rt2", 64'(load_use_hazard), 64'd1);
    id_instr = 26'h109_0000;   // rs=8, rt=9
    #1 check("lu match rs", 64'(load_use_hazard), 64'd1);
    id_instr = 26'h089_0000;   // rs=4, rt=9
    #1 check("lu no match", 64'(load_use_hazard), 64'd0);
    id_instr = 26'h040_0000;   // rs=2, rt=0
    tick();
    check("lu rt zero", 64'(load_use_hazard), 64'd0);
    id_valid = 1'b0; id_instr = 26'h048_0010;
    tick();
    check("lu invalid rt_addr", 64'(ex_rt_addr), 64'd8);
    check("lu invalid hazard", 64'(load_use_hazard), 64'd0);

    // Invalid slot with all control bits set
    id_valid = 1'b0; id_ctrl = 7'h7F;
    tick();
    check("invalid valid", 64'(ex_valid), 64'd0);
    check("invalid ctrl",  64'(ex_ctrl), 64'd0);

    // Counter saturation on the 2-bit instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat reset b", 64'(bubble_count_b), 64'd0);
    flush = 1'b1;
    tick(); check("sat 1", 64'(bubble_count_b), 64'd1);
    tick(); check("sat 2", 64'(bubble_count_b), 64'd2);
    tick(); check("sat 3", 64'(bubble_count_b), 64'd3);
    tick(); check("sat 4", 64'(bubble_count_b), 64'd3);
    tick(); check("sat 5", 64'(bubble_count_b), 64'd3);
    check("wide count 5", 64'(bubble_count), 64'd5);
    flush = 1'b0; stall = 1'b1;
    tick();
    check("stall no count", 64'(bubble_count), 64'd5);
    flush = 1'b1;
    tick();
    check("stall+flush count", 64'(bubble_count), 64'd6);
    flush = 1'b0; stall = 1'b0;
    tick();
    check("idle count", 64'(bubble_count), 64'd6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
